// File: rtl/multicycle_alu.sv
// Registered multi-cycle ALU with START/DONE handshake and barrel shifter.
// Optional iterative shift-add multiplier enabled by defining MULTICYCLE_ALU_MUL_EN.
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       select,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             err,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_FWD = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;

`ifdef MULTICYCLE_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIN = 2'd2} state_t;
`endif

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] result_r;
    logic             zero_r, overflow_r, err_r;
    logic             busy_s, done_s;
    logic             accept_s, is_mul_s, load_alu_s, mul_last_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s, alu_err_s;
    logic [SHW-1:0]   shamt_s;

    assign shamt_s    = data2[SHW-1:0];
    assign accept_s   = start && (state_r == S_IDLE || state_r == S_FIN);
    assign load_alu_s = accept_s && !is_mul_s;

`ifdef MULTICYCLE_ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_r, acc_r, acc_next_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [SHW-1:0]     cnt_r;

    assign is_mul_s   = (select == OP_MUL);
    assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign mul_last_s = (state_r == S_MUL) && (cnt_r == SHW'(WIDTH - 1));

    // Shift-add multiplier datapath: one partial product per MUL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (accept_s && is_mul_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, data1};
            mplier_r <= data2;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (state_r == S_MUL) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_next_s;
            cnt_r    <= cnt_r + SHW'(1);
        end else begin
            cnt_r    <= cnt_r;
        end
    end
`else
    assign is_mul_s   = 1'b0;
    assign mul_last_s = 1'b0;
`endif

    // Single-cycle operation results; unknown opcodes flag an error with a zero result.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        alu_err_s = 1'b0;
        case (select)
            OP_FWD: alu_res_s = data2;
            OP_ADD: begin
                alu_res_s = data1 + data2;
                alu_ovf_s = (data1[WIDTH-1] == data2[WIDTH-1]) && (alu_res_s[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = data1 - data2;
                alu_ovf_s = (data1[WIDTH-1] != data2[WIDTH-1]) && (alu_res_s[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND: alu_res_s = data1 & data2;
            OP_OR:  alu_res_s = data1 | data2;
            OP_XOR: alu_res_s = data1 ^ data2;
            OP_SLL: alu_res_s = data1 << shamt_s;
            OP_SRL: alu_res_s = data1 >> shamt_s;
            OP_SRA: alu_res_s = $unsigned($signed(data1) >>> shamt_s);
            OP_ROR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    alu_res_s[i] = data1[(i + int'(shamt_s)) % WIDTH];
                end
            end
            default: alu_err_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; FIN accepts a new START exactly like IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_FIN: begin
                if (accept_s) begin
`ifdef MULTICYCLE_ALU_MUL_EN
                    state_next_s = is_mul_s ? S_MUL : S_FIN;
`else
                    state_next_s = S_FIN;
`endif
                end else begin
                    state_next_s = S_IDLE;
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            S_MUL: begin
                if (mul_last_s) begin
                    state_next_s = S_FIN;
                end else begin
                    state_next_s = S_MUL;
                end
            end
`endif
            default: state_next_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
`ifdef MULTICYCLE_ALU_MUL_EN
            S_MUL:   busy_s = 1'b1;
`endif
            S_FIN:   done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Result and flag registers; updated only on completion so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b1;
            overflow_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (load_alu_s) begin
            result_r   <= alu_res_s;
            zero_r     <= (alu_res_s == {WIDTH{1'b0}});
            overflow_r <= alu_ovf_s;
            err_r      <= alu_err_s;
`ifdef MULTICYCLE_ALU_MUL_EN
        end else if (mul_last_s) begin
            result_r   <= acc_next_s[WIDTH-1:0];
            zero_r     <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            overflow_r <= |acc_next_s[2*WIDTH-1:WIDTH];
            err_r      <= 1'b0;
`endif
        end else begin
            result_r   <= result_r;
        end
    end

    assign result   = result_r;
    assign zero     = zero_r;
    assign overflow = overflow_r;
    assign err      = err_r;
    assign busy     = busy_s;
    assign done     = done_s;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=8).
// MUL scenarios are selected by MULTICYCLE_ALU_MUL_EN, matching the RTL build.
module tb_multicycle_alu;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] select;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [7:0] result;
    logic       zero;
    logic       overflow;
    logic       err;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .select(select),
        .data1(data1), .data2(data2), .result(result), .zero(zero),
        .overflow(overflow), .err(err), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for a single sampling edge; returns #1 after that edge.
    task automatic issue(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        start = 1'b1; select = s; data1 = a; data2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        int dones;
        rst_n = 1'b0; start = 1'b0; select = 4'b0000; data1 = 8'h00; data2 = 8'h00;
        #12;
        n_cmp++;
        if ({result, zero, overflow, err, busy, done} !== {8'h00, 5'b10000}) begin
            n_bad++;
            $display("FAIL reset_values: got res=%h z=%b o=%b e=%b b=%b d=%b expected 00 1 0 0 0 0",
                     result, zero, overflow, err, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        issue(4'b0001, 8'h11, 8'h22);
        n_cmp++;
        if (result !== 8'h33) begin
            n_bad++; $display("FAIL pre_reset_add: got %h expected 33", result);
        end
`ifdef MULTICYCLE_ALU_MUL_EN
        issue(4'b1010, 8'h0C, 8'h0A);
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_before_reset: got %b expected 1", busy);
        end
`endif
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({result, zero, overflow, err, busy, done} !== {8'h00, 5'b10000}) begin
            n_bad++;
            $display("FAIL async_reset: got res=%h z=%b o=%b e=%b b=%b d=%b expected 00 1 0 0 0 0",
                     result, zero, overflow, err, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++; $display("FAIL aborted_mul: got %0d done/busy cycles expected 0", dones);
        end
        issue(4'b0001, 8'h05, 8'h03);
        n_cmp++;
        if ({done, result, zero} !== {1'b1, 8'h08, 1'b0}) begin
            n_bad++; $display("FAIL add_after_reset: got d=%b res=%h z=%b expected 1 08 0", done, result, zero);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse_width: got %b expected 0", done);
        end
    endtask

    task automatic test_arith;
        logic [3:0] s_t [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0101};
        logic [7:0] a_t [5] = '{8'h7F, 8'h10, 8'h80, 8'h99, 8'hA5};
        logic [7:0] b_t [5] = '{8'h01, 8'h10, 8'h01, 8'h3C, 8'h0F};
        logic [7:0] r_t [5] = '{8'h80, 8'h00, 8'h7F, 8'h3C, 8'hAA};
        logic       z_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       o_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            issue(s_t[i], a_t[i], b_t[i]);
            n_cmp++;
            if ({done, result, zero, overflow, err} !== {1'b1, r_t[i], z_t[i], o_t[i], 1'b0}) begin
                n_bad++;
                $display("FAIL arith_%0d: got d=%b res=%h z=%b o=%b e=%b expected 1 %h %b %b 0",
                         i, done, result, zero, overflow, err, r_t[i], z_t[i], o_t[i]);
            end
        end
    endtask

    task automatic test_shifts;
        logic [3:0] s_t [6] = '{4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0110, 4'b1001};
        logic [7:0] b_t [6] = '{8'h02, 8'h03, 8'h03, 8'h04, 8'h09, 8'h00};
        logic [7:0] r_t [6] = '{8'h58, 8'h12, 8'hF2, 8'h69, 8'h2C, 8'h96};
        for (int i = 0; i < 6; i++) begin
            issue(s_t[i], 8'h96, b_t[i]);
            n_cmp++;
            if ({done, result, overflow, err} !== {1'b1, r_t[i], 2'b00}) begin
                n_bad++;
                $display("FAIL shift_%0d: got d=%b res=%h o=%b e=%b expected 1 %h 0 0",
                         i, done, result, overflow, err, r_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        start = 1'b1; select = 4'b0011; data1 = 8'hF0; data2 = 8'h3C;
        @(posedge clk); #1;
        n_cmp++;
        if ({done, result} !== {1'b1, 8'h30}) begin
            n_bad++; $display("FAIL b2b_and: got d=%b res=%h expected 1 30", done, result);
        end
        select = 4'b0100; data1 = 8'hF0; data2 = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({done, result} !== {1'b1, 8'hFF}) begin
            n_bad++; $display("FAIL b2b_or: got d=%b res=%h expected 1 FF", done, result);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: got d=%b expected 0", done);
        end
    endtask

    task automatic test_illegal;
        issue(4'b1100, 8'h12, 8'h34);
        n_cmp++;
        if ({done, result, zero, overflow, err} !== {1'b1, 8'h00, 3'b101}) begin
            n_bad++;
            $display("FAIL illegal_1100: got d=%b res=%h z=%b o=%b e=%b expected 1 00 1 0 1",
                     done, result, zero, overflow, err);
        end
        issue(4'b0001, 8'h01, 8'h01);
        n_cmp++;
        if ({result, err} !== {8'h02, 1'b0}) begin
            n_bad++; $display("FAIL err_clears: got res=%h e=%b expected 02 0", result, err);
        end
    endtask

`ifdef MULTICYCLE_ALU_MUL_EN
    task automatic test_mul;
        logic [7:0] a_t [3] = '{8'h0C, 8'h10, 8'hFF};
        logic [7:0] b_t [3] = '{8'h0A, 8'h10, 8'hFF};
        logic [7:0] r_t [3] = '{8'h78, 8'h00, 8'h01};
        logic       z_t [3] = '{1'b0, 1'b1, 1'b0};
        logic       o_t [3] = '{1'b0, 1'b1, 1'b1};
        int k;
        int busy_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(4'b1010, a_t[i], b_t[i]);
            busy_cnt = 0;
            for (k = 1; k <= 20 && done !== 1'b1; k++) begin
                if (busy === 1'b1) busy_cnt++;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (k !== 9 || busy_cnt !== 8 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL mul_timing_%0d: got done_cycle=%0d busy_cycles=%0d expected 9 8", i, k, busy_cnt);
            end
            n_cmp++;
            if ({result, zero, overflow, err} !== {r_t[i], z_t[i], o_t[i], 1'b0}) begin
                n_bad++;
                $display("FAIL mul_result_%0d: got res=%h z=%b o=%b e=%b expected %h %b %b 0",
                         i, result, zero, overflow, err, r_t[i], z_t[i], o_t[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int dones;
        int both;
        logic [7:0] res_at_done;
        issue(4'b1010, 8'h03, 8'h05);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; select = 4'b0001; data1 = 8'h01; data2 = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; both = 0; res_at_done = 8'hXX;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) begin dones++; res_at_done = result; end
            if (done === 1'b1 && busy === 1'b1) both++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dones !== 1 || both !== 0 || res_at_done !== 8'h0F) begin
            n_bad++;
            $display("FAIL start_while_busy: got dones=%0d overlap=%0d res=%h expected 1 0 0F",
                     dones, both, res_at_done);
        end
    endtask
`else
    task automatic test_mul_disabled;
        int busy_seen;
        issue(4'b1010, 8'h0C, 8'h0A);
        busy_seen = (busy === 1'b1) ? 1 : 0;
        n_cmp++;
        if ({done, result, zero, err, busy} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mul_disabled: got d=%b res=%h z=%b e=%b b=%b expected 1 00 1 1 0",
                     done, result, zero, err, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) busy_seen++;
        end
        n_cmp++;
        if (busy_seen !== 0) begin
            n_bad++; $display("FAIL mul_disabled_busy: got %0d busy cycles expected 0", busy_seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_shifts();
        test_back_to_back();
        test_illegal();
`ifdef MULTICYCLE_ALU_MUL_EN
        test_mul();
        test_start_while_busy();
`else
        test_mul_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered ALU for the next processor revision. Supports all existing single-cycle operations and adds subtract, XOR, a full barrel shifter (SLL/SRL/SRA/ROR) and an optional iterative shift-add multiplier. Operands are captured on a START/DONE handshake so the control unit can stall on multi-cycle operations. It sits between the register file read ports and the write-back mux.

## Interface
- WIDTH, 8, operand and result width; power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled on rising CLK when the block is not BUSY.
- SELECT  in  4  opcode, captured with START.
- DATA1  in  WIDTH  operand A / shift source, captured with START.
- DATA2  in  WIDTH  operand B / shift amount (low SHW bits), captured with START.
- RESULT  out  WIDTH  registered result; holds until the next completion.
- ZERO  out  1  registered; 1 when RESULT == 0.
- OVERFLOW  out  1  registered; meaning depends on opcode.
- ERR  out  1  registered; 1 when the completed opcode was unsupported.
- BUSY  out  1  1 while a multiply iterates.
- DONE  out  1  single-cycle pulse; RESULT/flags valid from this cycle.

## Operation
- Opcodes:
  - 0000 FWD = B
  - 0001 ADD = A+B
  - 0010 SUB = A−B
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 SLL
  - 0111 SRL (zero fill)
  - 1000 SRA (sign fill)
  - 1001 ROR
  - 1010 MUL (low WIDTH bits of the unsigned product)
- Opcodes 1011–1111 are illegal: RESULT=0, ZERO=1, OVERFLOW=0, ERR=1.
- Shift and rotate amount = DATA2[SHW-1:0], i.e. modulo WIDTH. Amount 0 passes A unchanged.
- OVERFLOW:
  - ADD/SUB: two's-complement signed overflow.
  - MUL: any nonzero product bit at or above WIDTH.
  - All other opcodes: 0.
- All arithmetic wraps modulo 2^WIDTH. Carry-out is not exported.
- FSM states: IDLE, MUL, FIN.
  - IDLE, START with non-MUL opcode: compute, register outputs, go to FIN.
  - IDLE, START with MUL: load multiplicand, multiplier, accumulator=0, counter=0, go to MUL.
  - MUL: each cycle, if multiplier LSB=1 add the multiplicand (2·WIDTH-bit accumulator); shift multiplicand left and multiplier right; counter++. After WIDTH iterations, register outputs and go to FIN.
  - FIN: DONE=1 for this one cycle. A START in FIN is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- START while BUSY is ignored, with no queuing. Inputs are ignored except when START is accepted.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - state=IDLE
  - RESULT=0, ZERO=1, OVERFLOW=0, ERR=0, BUSY=0, DONE=0
- Reset mid-multiply aborts the operation; no DONE is issued.
- Non-MUL latency: START sampled at edge n, DONE high and RESULT valid after edge n+1.
- MUL latency: BUSY high from edge n+1 through edge n+WIDTH. DONE high after edge n+WIDTH+1.
- Throughput:
  - One non-MUL operation per 2 cycles from IDLE.
  - One per cycle when START is held through FIN.
- BUSY and DONE are never high together.

## Configuration
- MULTICYCLE_ALU_MUL_EN
  - Defined: MUL is implemented as above, and the MUL state, counter and accumulator exist.
  - Undefined: opcode 1010 is treated as illegal (single-cycle, ERR=1, RESULT=0). BUSY is tied to 0 and no MUL state or datapath is synthesised.

## Test plan
- Reset: hold RESET_N=0 mid-MUL.
  - Outputs go to reset values immediately.
  - After release, ADD 0x05+0x03 → RESULT=0x08, ZERO=0, DONE 1 cycle after START.
- Add/sub flags:
  - ADD 0x7F+0x01 → 0x80, OVERFLOW=1.
  - SUB 0x10−0x10 → 0x00, ZERO=1, OVERFLOW=0.
  - SUB 0x80−0x01 → 0x7F, OVERFLOW=1.
- Shifts, A=0x96:
  - SLL by 2 → 0x58.
  - SRL by 3 → 0x12.
  - SRA by 3 → 0xF2.
  - ROR by 4 → 0x69.
  - SLL with DATA2=0x09 (amount 1) → 0x2C.
- MUL (macro defined):
  - 0x0C×0x0A → 0x78, OVERFLOW=0, BUSY 8 cycles, DONE at cycle 9.
  - 0x10×0x10 → 0x00, ZERO=1, OVERFLOW=1.
  - START pulsed during BUSY → ignored, with exactly one DONE.
- Back-to-back: START held across FIN for AND 0xF0&0x3C then OR 0xF0|0x0F → DONE on consecutive cycles with RESULT 0x30 then 0xFF.
- Illegal and macro-off:
  - SELECT=1100 → RESULT=0, ERR=1.
  - With MULTICYCLE_ALU_MUL_EN undefined, SELECT=1010 → ERR=1, BUSY stays 0, DONE after 1 cycle.
